ifm_feeder: RTL and testbench

Upstream input-feature-map feeder for the 8-row systolic array. It accepts one column of HEIGHT signed activations per handshake from the on-chip buffer and skews the rows diagonally so that row h reaches the array h cycles after row 0. It generates the per-row `en_i` and `clr_i` strobes that travel with the data. It also counts a programmed tile length, drains the skew pipeline, and signals completion to the tile controller.

---
 rtl/feeder_pkg.sv | 30 +++
 rtl/ifm_feeder_skew_line.sv | 69 ++++++
 rtl/ifm_feeder.sv | 143 ++++++++++++++
 tb/tb_ifm_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types and constants for the input-feature-map feeder.
package feeder_pkg;

    localparam int HEIGHT_DEF = 8;
    localparam int IWIDTH_DEF = 8;
    localparam int CNTW_DEF   = 16;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // One element travelling down a row's skew chain
    typedef struct packed {
        logic                         en;
        logic                         clr;
        logic signed [IWIDTH_DEF-1:0] data;
    } skew_entry_t;

    // Bubbles needed after the last accept so the deepest row empties
    function automatic int drain_len(input int height);
        return height - 1;
    endfunction

    localparam int DRAIN_LEN = HEIGHT_DEF - 1;

endpackage

// File: rtl/ifm_feeder_skew_line.sv
// skew_line: fixed-depth delay chain carrying en, clr and data for one array row.
// The data stages load only when the entry arriving at them is valid, so the
// tail holds the last valid value during bubbles. With ZERO_TAIL set, the
// last stage loads zero for a bubble instead, so the output reads 0 whenever
// en_out is low.
module skew_line #(
    parameter int DEPTH     = 1,
    parameter int DW        = 8,
    parameter bit ZERO_TAIL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic          clr_in,
    input  logic [DW-1:0] data_in,
    output logic          en_out,
    output logic          clr_out,
    output logic [DW-1:0] data_out
);

    logic [DEPTH:0]             en_chain_s;
    logic [DEPTH:0]             clr_chain_s;
    logic [DEPTH:0][DW-1:0]     data_chain_s;
    logic [DEPTH-1:0]           en_q;
    logic [DEPTH-1:0]           en_d;
    logic [DEPTH-1:0]           clr_q;
    logic [DEPTH-1:0]           clr_d;
    logic [DEPTH-1:0][DW-1:0]   data_q;
    logic [DEPTH-1:0][DW-1:0]   data_d;

    // Index k of each chain vector is the input of stage k; index DEPTH is the tail
    assign en_chain_s   = {en_q, en_in};
    assign clr_chain_s  = {clr_q, clr_in};
    assign data_chain_s = {data_q, data_in};

    assign en_out   = en_chain_s[DEPTH];
    assign clr_out  = clr_chain_s[DEPTH];
    assign data_out = data_chain_s[DEPTH];

    // Next-stage values: control always shifts, data shifts only with a valid entry
    always_comb begin
        en_d   = en_chain_s[DEPTH-1:0];
        clr_d  = clr_chain_s[DEPTH-1:0];
        data_d = data_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (en_chain_s[k]) begin
                data_d[k] = data_chain_s[k];
            end else if (ZERO_TAIL && (k == DEPTH - 1)) begin
                data_d[k] = {DW{1'b0}};
            end else begin
                data_d[k] = data_q[k];
            end
        end
    end

    // Chain registers; reset empties every in-flight entry at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= {DEPTH{1'b0}};
            clr_q  <= {DEPTH{1'b0}};
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            clr_q  <= clr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/ifm_feeder.sv
// ifm_feeder: accepts activation columns, skews row h by h cycles toward the
// systolic array, counts a programmed tile length, drains the skew and pulses done.
// Optional build macro FEEDER_ZERO_GATE_EN: force ifm[h] to zero whenever en_i[h] is low.
module ifm_feeder
    import feeder_pkg::*;
#(
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int IWIDTH = IWIDTH_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [CNTW-1:0]                     tile_len,
    output logic                                busy,
    output logic                                done,
    input  logic                                hold,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [HEIGHT-1:0][IWIDTH-1:0] in_data,
    output logic [HEIGHT-1:0]                   en_i,
    output logic [HEIGHT-1:0]                   clr_i,
    output logic signed [HEIGHT-1:0][IWIDTH-1:0] ifm
);

    localparam int DRAIN_N = drain_len(HEIGHT);
    localparam int DCW     = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

`ifdef FEEDER_ZERO_GATE_EN
    localparam bit ZERO_TAIL = 1'b1;
`else
    localparam bit ZERO_TAIL = 1'b0;
`endif

    feeder_state_e   state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            accept_s;
    logic            first_s;

    // A vector is taken only while streaming and not stalled by the controller
    assign in_ready = (state_q == ST_STREAM) && !hold;
    assign accept_s = in_ready && in_valid;
    assign first_s  = accept_s && (cnt_q == {CNTW{1'b0}});
    assign busy     = busy_q;
    assign done     = done_q;

    // Next state, vector counter, drain counter and registered status
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (tile_len != {CNTW{1'b0}}) begin
                        len_d   = tile_len;
                        cnt_d   = {CNTW{1'b0}};
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s) begin
                    cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                    if (cnt_q == len_q - {{(CNTW-1){1'b0}}, 1'b1}) begin
                        if (DRAIN_N == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = DCW'(DRAIN_N - 1);
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (drain_q == {DCW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNTW{1'b0}};
            len_q   <= {CNTW{1'b0}};
            drain_q <= {DCW{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Row h gets h+1 stages, so row h reaches the array h cycles after row 0
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        skew_line #(
            .DEPTH     (h + 1),
            .DW        (IWIDTH),
            .ZERO_TAIL (ZERO_TAIL)
        ) u_skew (
            .clk      (clk),
            .rst      (rst),
            .en_in    (accept_s),
            .clr_in   (first_s),
            .data_in  (in_data[h]),
            .en_out   (en_i[h]),
            .clr_out  (clr_i[h]),
            .data_out (ifm[h])
        );
    end

endmodule

// File: tb/tb_ifm_feeder.sv
// Self-checking bench for ifm_feeder: directed tiles plus randomized tiles,
// compared each cycle against a cycle-scheduled behavioural model.
module tb_ifm_feeder;

    localparam int HEIGHT = 8;
    localparam int IWIDTH = 8;
    localparam int CNTW   = 16;
    localparam int RING   = 32;
    localparam int BIG    = 32'h7fffffff;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 start;
    logic [CNTW-1:0]                      tile_len;
    logic                                 busy;
    logic                                 done;
    logic                                 hold;
    logic                                 in_valid;
    logic                                 in_ready;
    logic signed [HEIGHT-1:0][IWIDTH-1:0] in_data;
    logic [HEIGHT-1:0]                    en_i;
    logic [HEIGHT-1:0]                    clr_i;
    logic signed [HEIGHT-1:0][IWIDTH-1:0] ifm;

    ifm_feeder #(.HEIGHT(HEIGHT), .IWIDTH(IWIDTH), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tile_len (tile_len),
        .busy     (busy),
        .done     (done),
        .hold     (hold),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .ifm      (ifm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: what each output must show in a given cycle
    logic [HEIGHT-1:0]  r_en   [RING];
    logic [HEIGHT-1:0]  r_clr  [RING];
    logic [IWIDTH-1:0]  r_data [RING][HEIGHT];
    logic [IWIDTH-1:0]  last_v [HEIGHT];
    bit                 m_stream;
    int                 m_stream_from, m_len, m_k;
    int                 m_busy_from, m_idle_from, m_done_at;

    // run-loop knobs
    bit rand_valid, rand_hold, hold2, stray;
    int data_mode, stop_k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < RING; s++) begin
            r_en[s]  = '0;
            r_clr[s] = '0;
            for (int h = 0; h < HEIGHT; h++) r_data[s][h] = '0;
        end
        for (int h = 0; h < HEIGHT; h++) last_v[h] = '0;
        m_stream      = 1'b0;
        m_stream_from = BIG;
        m_len         = 0;
        m_k           = 0;
        m_busy_from   = 0;
        m_idle_from   = 0;
        m_done_at     = -1;
    endfunction

    function automatic bit stream_on(input int t);
        return m_stream && (t >= m_stream_from);
    endfunction

    // apply the feeder's rules to the inputs present in the current cycle
    function automatic void model_step();
        int s;
        if (rst) begin
            return;
        end
        if (start && cyc >= m_idle_from) begin
            m_busy_from = cyc + 1;
            if (tile_len != 0) begin
                m_stream      = 1'b1;
                m_stream_from = cyc + 1;
                m_len         = int'(tile_len);
                m_k           = 0;
                m_idle_from   = BIG;
            end else begin
                m_done_at   = cyc + 1;
                m_idle_from = cyc + 2;
            end
        end else if (stream_on(cyc) && in_valid && !hold) begin
            for (int h = 0; h < HEIGHT; h++) begin
                s = (cyc + 1 + h) % RING;
                r_en[s][h]   = 1'b1;
                r_clr[s][h]  = (m_k == 0);
                r_data[s][h] = in_data[h];
            end
            m_k++;
            if (m_k == m_len) begin
                m_stream    = 1'b0;
                m_done_at   = cyc + HEIGHT;
                m_idle_from = cyc + HEIGHT + 1;
            end
        end
    endfunction

    // one clock: check handshake, advance model, then check registered outputs
    task automatic tick();
        int s;
        logic [HEIGHT-1:0][IWIDTH-1:0] exp_ifm;
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, (!rst && stream_on(cyc) && !hold)});
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        s = cyc % RING;
        for (int h = 0; h < HEIGHT; h++) begin
            if (r_en[s][h]) last_v[h] = r_data[s][h];
`ifdef FEEDER_ZERO_GATE_EN
            exp_ifm[h] = r_en[s][h] ? r_data[s][h] : '0;
`else
            exp_ifm[h] = last_v[h];
`endif
        end
        check("en_i",  {56'd0, en_i},  {56'd0, r_en[s]});
        check("clr_i", {56'd0, clr_i}, {56'd0, r_clr[s]});
        check("ifm",   ifm, exp_ifm);
        check("busy",  {63'd0, busy}, {63'd0, (cyc >= m_busy_from && cyc < m_idle_from)});
        check("done",  {63'd0, done}, {63'd0, (cyc == m_done_at)});
        r_en[s]  = '0;
        r_clr[s] = '0;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_en_i",  {56'd0, en_i},  64'd0);
        check("rst_clr_i", {56'd0, clr_i}, 64'd0);
        check("rst_ifm",   ifm,            64'd0);
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_done",  {63'd0, done},  64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        model_clear();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [CNTW-1:0] len);
        start    = 1'b1;
        tile_len = len;
        in_valid = 1'($urandom_range(0, 1));
        hold     = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic set_data();
        for (int h = 0; h < HEIGHT; h++) begin
            case (data_mode)
                0:       in_data[h] = IWIDTH'(16 * m_k + h);
                1:       in_data[h] = IWIDTH'($urandom);
                default: in_data[h] = 8'h80;
            endcase
        end
    endtask

    // drive a tile until the model says it is idle again (or stop_k is reached)
    task automatic run_tile(input int budget);
        int  n = 0;
        int  hold_used = 0;
        bit  stray_done = 1'b0;
        bit  hh;
        while (!(m_idle_from != BIG && cyc >= m_idle_from) && n < budget
               && !(stop_k >= 0 && m_k >= stop_k)) begin
            in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            hh = hold2 && (m_k == 2) && (hold_used < 2);
            if (hh) hold_used++;
            hold = rand_hold ? ($urandom_range(0, 4) == 0) : hh;
            if (stray && m_k == 1 && !stray_done) begin
                start      = 1'b1;
                tile_len   = 16'd99;
                stray_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            set_data();
            tick();
            n++;
        end
        check("tile_budget", {63'd0, (n < budget)}, 64'd1);
        start    = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            for (int h = 0; h < HEIGHT; h++) in_data[h] = IWIDTH'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic knobs(input bit rv, input bit rh, input bit h2, input bit st,
                         input int dm, input int sk);
        rand_valid = rv;
        rand_hold  = rh;
        hold2      = h2;
        stray      = st;
        data_mode  = dm;
        stop_k     = sk;
    endtask

    initial begin
        start    = 1'b0;
        tile_len = '0;
        hold     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        @(negedge clk);
        do_reset(2);
        idle_gap(2);

        // tile of 4, in_valid high, patterned data
        knobs(1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        do_start(16'd4);
        run_tile(100);
        idle_gap(3);

        // same tile with a 2-cycle hold after the 2nd accept
        knobs(1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
        do_start(16'd4);
        run_tile(100);
        idle_gap(2);

        // zero-length tile
        do_start(16'd0);
        knobs(1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        run_tile(20);
        idle_gap(2);

        // stray start with tile_len=99 during STREAM is dropped
        knobs(1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        do_start(16'd4);
        run_tile(100);
        idle_gap(2);

        // reset two cycles after the 3rd accept
        knobs(1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        do_start(16'd4);
        run_tile(100);
        idle_gap(2);
        do_reset(2);
        idle_gap(12);

        // single-vector tile of -128 on every row
        knobs(1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
        do_start(16'd1);
        run_tile(100);
        idle_gap(3);

        // randomized tiles: random valid, hold, data, lengths and stray starts
        for (int i = 0; i < 12; i++) begin
            knobs(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1, -1);
            do_start(CNTW'($urandom_range(0, 20)));
            run_tile(400);
            idle_gap(int'($urandom_range(0, 3)));
        end

        // longest tile: counter must reach 2^CNTW-1 without wrapping
        knobs(1'b0, 1'b0, 1'b0, 1'b0, 1, -1);
        do_start(16'hFFFF);
        run_tile(70000);
        idle_gap(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
